// File: rtl/dcache_wt_pkg.sv
// dcache_wt_pkg: shared types and constants for the dcache_wt slice.
//   state_t       : controller states (IDLE / RD_MISS / WR_THRU)
//   LINES_DEFAULT : default number of one-word lines
//   tag_width()   : tag width for a given byte-address width and line count
package dcache_wt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_THRU = 2'd2
  } state_t;

  localparam int unsigned LINES_DEFAULT = 16;

  function automatic int unsigned tag_width(input int unsigned addr_w,
                                            input int unsigned lines);
    return addr_w - $clog2(lines) - 2;
  endfunction

endpackage

// File: rtl/dcache_wt_lines.sv
// dcache_lines: valid/tag/data storage for the direct-mapped cache.
//   clock, reset         : clock; synchronous active-low clear of all valid bits
//   rd_idx               : combinational read index
//   rd_valid/tag/data    : contents of line rd_idx
//   we, wr_idx/tag/data  : single synchronous write port (sets valid)
module dcache_lines #(
  parameter int unsigned LINES  = 16,
  parameter int unsigned TAG_W  = 26,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = $clog2(LINES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES];

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && we) begin
      tag_arr[wr_idx]  <= wr_tag;
      data_arr[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_arr[rd_idx];
  assign rd_data  = data_arr[rd_idx];

endmodule

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache
// between the CPU MEM stage and a multi-cycle backing memory.
//   clock, reset (sync, active-low)
//   cpu_rd, cpu_wr, cpu_addr, cpu_wdata -> cpu_rdata, cpu_stall
//   mem_req, mem_we, mem_addr, mem_wdata -> backing memory; mem_ack, mem_rdata <- it
// Optional: define DCACHE_WBUF_EN for a one-entry posted write buffer.
module dcache_wt
  import dcache_wt_pkg::*;
#(
  parameter int unsigned LINES  = LINES_DEFAULT,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = tag_width(ADDR_W, LINES);

  state_t state, state_nx;
  logic [ADDR_W-3:0] lat_word;
  logic [DATA_W-1:0] lat_wdata;
  logic              capture;

  logic [IDX_W-1:0] cpu_idx;
  logic [TAG_W-1:0] cpu_tag;
  logic             unused_addr_lsbs;
  assign cpu_idx          = cpu_addr[IDX_W+1:2];
  assign cpu_tag          = cpu_addr[ADDR_W-1:IDX_W+2];
  assign unused_addr_lsbs = ^cpu_addr[1:0];

  logic [IDX_W-1:0] lat_idx;
  logic [TAG_W-1:0] lat_tag;
  assign lat_idx = lat_word[IDX_W-1:0];
  assign lat_tag = lat_word[ADDR_W-3:IDX_W];

  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [DATA_W-1:0] line_data;
  logic              hit;
  logic              arr_we;
  logic [IDX_W-1:0]  arr_idx;
  logic [TAG_W-1:0]  arr_tag;
  logic [DATA_W-1:0] arr_data;

  dcache_lines #(
    .LINES (LINES),
    .TAG_W (TAG_W),
    .DATA_W(DATA_W)
  ) u_lines (
    .clock   (clock),
    .reset   (reset),
    .rd_idx  (cpu_idx),
    .rd_valid(line_valid),
    .rd_tag  (line_tag),
    .rd_data (line_data),
    .we      (arr_we),
    .wr_idx  (arr_idx),
    .wr_tag  (arr_tag),
    .wr_data (arr_data)
  );

  assign hit = line_valid && (line_tag == cpu_tag);

`ifndef DCACHE_WBUF_EN
  // Set for the one cycle after a write-through ack so the still-asserted
  // store is seen as retired rather than issued again.
  logic done;
  always_ff @(posedge clock) begin
    if (!reset) done <= 1'b0;
    else        done <= (state == ST_WR_THRU) && mem_ack;
  end
`endif

  always_comb begin
    state_nx  = state;
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    capture   = 1'b0;
    arr_we    = 1'b0;
    arr_idx   = cpu_idx;
    arr_tag   = cpu_tag;
    arr_data  = cpu_wdata;
    case (state)
      ST_IDLE: begin
        if (cpu_wr) begin
`ifdef DCACHE_WBUF_EN
          // Buffer is empty in IDLE: post the store without stalling.
          capture  = 1'b1;
          arr_we   = hit;
          state_nx = ST_WR_THRU;
`else
          if (!done) begin
            cpu_stall = 1'b1;
            capture   = 1'b1;
            arr_we    = hit;
            state_nx  = ST_WR_THRU;
          end
`endif
        end else if (cpu_rd) begin
          if (hit) begin
            cpu_rdata = line_data;
          end else begin
            cpu_stall = 1'b1;
            capture   = 1'b1;
            state_nx  = ST_RD_MISS;
          end
        end
      end
      ST_RD_MISS: begin
        cpu_stall = 1'b1;
        if (mem_ack) begin
          arr_we   = 1'b1;
          arr_idx  = lat_idx;
          arr_tag  = lat_tag;
          arr_data = mem_rdata;
          state_nx = ST_IDLE;
        end
      end
      ST_WR_THRU: begin
`ifdef DCACHE_WBUF_EN
        // WR_THRU doubles as "buffer draining"; read hits proceed, while a
        // second store or a read miss waits for the drain to finish first.
        if (cpu_wr) begin
          cpu_stall = 1'b1;
        end else if (cpu_rd) begin
          if (hit) cpu_rdata = line_data;
          else     cpu_stall = 1'b1;
        end
`else
        cpu_stall = 1'b1;
`endif
        if (mem_ack) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      lat_word  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        lat_word  <= cpu_addr[ADDR_W-1:2];
        lat_wdata <= cpu_wdata;
      end
    end
  end

  assign mem_req   = (state != ST_IDLE);
  assign mem_we    = (state == ST_WR_THRU);
  assign mem_addr  = mem_req ? {lat_word, 2'b00} : '0;
  assign mem_wdata = mem_we ? lat_wdata : '0;

endmodule

// File: tb/tb_dcache_wt.sv
`timescale 1ns/1ps
module tb_dcache_wt;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dcache_wt #(.LINES(16), .ADDR_W(32), .DATA_W(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .cpu_rd   (cpu_rd),
    .cpu_wr   (cpu_wr),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  // Backing memory: ack after the request has been seen for 'lat' edges.
  int unsigned lat = 3;
  int unsigned mem_cnt = 0;
  logic [31:0] mem_store [256];
  logic [255:0] written = '0;

  function automatic logic [31:0] preload(input logic [31:0] a);
    case (a)
      32'h40:  return 32'hDEADBEEF;
      32'h80:  return 32'hCAFEF00D;
      32'h100: return 32'h11112222;
      default: return ~a;
    endcase
  endfunction

  assign mem_ack   = mem_req && (mem_cnt == lat);
  assign mem_rdata = written[mem_addr[9:2]] ? mem_store[mem_addr[9:2]] : preload(mem_addr);

  always @(posedge clock) begin
    if (!reset || !mem_req || mem_ack) mem_cnt <= 0;
    else                               mem_cnt <= mem_cnt + 1;
    if (reset && mem_req && mem_ack && mem_we) begin
      mem_store[mem_addr[9:2]] <= mem_wdata;
      written[mem_addr[9:2]]   <= 1'b1;
    end
  end

  // Scoreboard
  typedef struct { int stall; logic chk_data; logic [31:0] data; } op_exp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;
  op_exp_t  op_q[$];
  mem_exp_t mem_q[$];
  int run = 0;

  always @(negedge clock) begin
    op_exp_t  e;
    mem_exp_t m;
    if (!reset) begin
      run = 0;
    end else begin
      if (cpu_rd || cpu_wr) begin
        if (cpu_stall) begin
          run++;
        end else begin
          checks++;
          if (op_q.size() == 0) begin
            errors++;
            $display("FAIL op_unexpected: completion at addr %h with no expectation", cpu_addr);
          end else begin
            e = op_q.pop_front();
            if (run != e.stall) begin
              errors++;
              $display("FAIL stall_cycles addr %h: got %0d expected %0d", cpu_addr, run, e.stall);
            end
            if (e.chk_data) begin
              checks++;
              if (cpu_rdata !== e.data) begin
                errors++;
                $display("FAIL rdata addr %h: got %h expected %h", cpu_addr, cpu_rdata, e.data);
              end
            end
          end
          run = 0;
        end
      end
      if (mem_req && mem_ack) begin
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected: we=%b addr=%h with no expectation", mem_we, mem_addr);
        end else begin
          m = mem_q.pop_front();
          if (mem_we !== m.we || mem_addr !== m.addr || (m.we && mem_wdata !== m.wdata)) begin
            errors++;
            $display("FAIL mem_txn: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                     mem_we, mem_addr, mem_wdata, m.we, m.addr, m.wdata);
          end
        end
      end
    end
  end

  task automatic exp_mem(input logic we, input logic [31:0] a, input logic [31:0] wd);
    mem_exp_t m;
    m.we = we; m.addr = a; m.wdata = wd;
    mem_q.push_back(m);
  endtask

  // Called at posedge+1; returns at posedge+1 after the cycle the op retires.
  task automatic op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                    input int exp_stall, input logic chk, input logic [31:0] exp_data);
    op_exp_t e;
    bit      ok;
    e.stall = exp_stall; e.chk_data = chk; e.data = exp_data;
    op_q.push_back(e);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!cpu_stall) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL op_timeout addr %h: stall still %b after 100 cycles", a, cpu_stall);
    end
    @(posedge clock); #1;
  endtask

  task automatic gap();
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    @(negedge clock);
    checks++;
    if (cpu_stall !== 1'b0 || mem_req !== 1'b0 || cpu_rdata !== 32'h0) begin
      errors++;
      $display("FAIL idle_outputs: stall=%b mem_req=%b rdata=%h expected 0 0 0", cpu_stall, mem_req, cpu_rdata);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        cpu_stall !== 1'b0 || cpu_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h stall=%b rdata=%h expected all 0",
               mem_req, mem_we, mem_addr, mem_wdata, cpu_stall, cpu_rdata);
    end
    @(posedge clock); #1;

`ifdef DCACHE_WBUF_EN
    lat = 4;
    exp_mem(1'b1, 32'h40, 32'hAAAA0001);
    op(1'b0, 1'b1, 32'h40, 32'hAAAA0001, 0, 1'b0, 32'h0);
    exp_mem(1'b1, 32'h44, 32'hBBBB0002);
    op(1'b0, 1'b1, 32'h44, 32'hBBBB0002, 5, 1'b0, 32'h0);
    exp_mem(1'b0, 32'h48, 32'h0);
    op(1'b1, 1'b0, 32'h48, 32'h0, 11, 1'b1, 32'hFFFFFFB7);
    gap();
    exp_mem(1'b0, 32'h40, 32'h0);
    op(1'b1, 1'b0, 32'h40, 32'h0, 6, 1'b1, 32'hAAAA0001);
    gap();
`else
    // Cold read miss, then hit
    exp_mem(1'b0, 32'h40, 32'h0);
    op(1'b1, 1'b0, 32'h40, 32'h0, 5, 1'b1, 32'hDEADBEEF);
    gap();
    op(1'b1, 1'b0, 32'h40, 32'h0, 0, 1'b1, 32'hDEADBEEF);
    gap();
    // Write hit goes through and updates the line
    exp_mem(1'b1, 32'h40, 32'h12345678);
    op(1'b0, 1'b1, 32'h40, 32'h12345678, 5, 1'b0, 32'h0);
    op(1'b1, 1'b0, 32'h40, 32'h0, 0, 1'b1, 32'h12345678);
    gap();
    // Conflict eviction on index 0
    exp_mem(1'b0, 32'h80, 32'h0);
    op(1'b1, 1'b0, 32'h80, 32'h0, 5, 1'b1, 32'hCAFEF00D);
    exp_mem(1'b0, 32'h40, 32'h0);
    op(1'b1, 1'b0, 32'h40, 32'h0, 5, 1'b1, 32'h12345678);
    exp_mem(1'b0, 32'h80, 32'h0);
    op(1'b1, 1'b0, 32'h80, 32'h0, 5, 1'b1, 32'hCAFEF00D);
    gap();
    // Write miss does not allocate
    exp_mem(1'b1, 32'hC4, 32'hA5A5A5A5);
    op(1'b0, 1'b1, 32'hC4, 32'hA5A5A5A5, 5, 1'b0, 32'h0);
    exp_mem(1'b0, 32'hC4, 32'h0);
    op(1'b1, 1'b0, 32'hC4, 32'h0, 5, 1'b1, 32'hA5A5A5A5);
    gap();
    // rd+wr together: write wins (miss on index 0), line keeps 0x80
    exp_mem(1'b1, 32'h40, 32'h0BADF00D);
    op(1'b1, 1'b1, 32'h40, 32'h0BADF00D, 5, 1'b0, 32'h0);
    op(1'b1, 1'b0, 32'h80, 32'h0, 0, 1'b1, 32'hCAFEF00D);
    gap();
    // Zero-latency memory: minimum penalty
    lat = 0;
    exp_mem(1'b0, 32'h100, 32'h0);
    op(1'b1, 1'b0, 32'h100, 32'h0, 2, 1'b1, 32'h11112222);
    gap();
    lat = 3;
    // Reset during RD_MISS cycle 2 abandons the fill and clears valid bits
    cpu_rd = 1'b1; cpu_addr = 32'h40;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0; cpu_rd = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: req=%b stall=%b expected 0 0", mem_req, cpu_stall);
    end
    @(posedge clock); #1;
    exp_mem(1'b0, 32'h100, 32'h0);
    op(1'b1, 1'b0, 32'h100, 32'h0, 5, 1'b1, 32'h11112222);
    exp_mem(1'b0, 32'h40, 32'h0);
    op(1'b1, 1'b0, 32'h40, 32'h0, 5, 1'b1, 32'h0BADF00D);
    gap();
`endif

    repeat (3) @(posedge clock);
    checks++;
    if (op_q.size() != 0 || mem_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: ops=%0d mem=%0d expected 0 0", op_q.size(), mem_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
